// File: rtl/dbg_access_arbiter.sv
// dbg_access_arbiter
// Round-robin arbiter and sequencer for the shared debug register bus.
// Grants one debug front-end at a time. Drives a registered addr/wdata/write
// command with a level-held enable_o strobe, and returns read data,
// completion and error to the granted requester as a single-cycle pulse.
// Optional feature: define DBG_ARB_TIMEOUT_EN to abort any access that is
// not acknowledged within TIMEOUT_CYCLES cycles of ACCESS.
module dbg_access_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  // requester side
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            req_error_o,
  output logic [DATA_WIDTH-1:0]         req_rdata_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  // debug register block side
  output logic [ADDR_WIDTH-1:0]         addr_o,
  output logic [DATA_WIDTH-1:0]         wdata_o,
  output logic                          write_o,
  output logic                          enable_o,
  input  logic [DATA_WIDTH-1:0]         rdata_i,
  input  logic                          ready_i,
  input  logic                          error_i
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // Elaboration-time guards on the legal parameter ranges.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("dbg_access_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("dbg_access_arbiter: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q;
  logic [PTR_W-1:0]        gnt_idx_q;
  logic [NUM_REQ-1:0]      grant_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;

  logic                    sel_found;
  logic [PTR_W-1:0]        sel_idx;
  logic [NUM_REQ-1:0]      sel_onehot;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    sel_write;
  logic                    timeout_hit;

  // Round-robin pick: first valid requester above the pointer, then wrap.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    sel_addr   = '0;
    sel_wdata  = '0;
    sel_write  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && req_valid_i[i] && (i > int'(rr_ptr_q))) begin
        sel_found     = 1'b1;
        sel_idx       = PTR_W'(i);
        sel_onehot[i] = 1'b1;
        sel_addr      = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata     = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_write     = req_write_i[i];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && req_valid_i[i] && (i <= int'(rr_ptr_q))) begin
        sel_found     = 1'b1;
        sel_idx       = PTR_W'(i);
        sel_onehot[i] = 1'b1;
        sel_addr      = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata     = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_write     = req_write_i[i];
      end
    end
  end

`ifdef DBG_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;

  // Count ACCESS cycles; held at zero outside ACCESS so each access starts fresh.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else if (state_q == S_ACCESS) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end else begin
      to_cnt_q <= '0;
    end
  end

  // Fires in the TIMEOUT_CYCLES-th ACCESS cycle; a coincident ready_i wins.
  assign timeout_hit = (state_q == S_ACCESS) && !ready_i &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> ACCESS on any request, ACCESS -> RESP on ack/timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (sel_found) state_d = S_ACCESS;
      S_ACCESS: if (ready_i || timeout_hit) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Command, grant, pointer and response capture registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q  <= PTR_W'(NUM_REQ - 1);
      gnt_idx_q <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (sel_found) begin
            gnt_idx_q <= sel_idx;
            grant_q   <= sel_onehot;
            addr_q    <= sel_addr;
            wdata_q   <= sel_wdata;
            write_q   <= sel_write;
          end
        end
        S_ACCESS: begin
          if (ready_i) begin
            rdata_q <= write_q ? '0 : rdata_i;
            err_q   <= error_i;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        S_RESP: begin
          rr_ptr_q <= gnt_idx_q;
          grant_q  <= '0;
          rdata_q  <= '0;
          err_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Output decode from state and captured registers.
  always_comb begin
    enable_o    = (state_q == S_ACCESS);
    busy_o      = (state_q != S_IDLE);
    grant_o     = grant_q;
    req_ready_o = (state_q == S_RESP) ? grant_q : '0;
    req_error_o = (state_q == S_RESP && err_q) ? grant_q : '0;
    req_rdata_o = (state_q == S_RESP) ? rdata_q : '0;
  end

  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign write_o = write_q;

endmodule

// File: tb/tb_dbg_access_arbiter.sv
// Directed self-checking bench for dbg_access_arbiter (NUM_REQ=3, 32-bit bus,
// TIMEOUT_CYCLES=16). The timeout scenario depends on DBG_ARB_TIMEOUT_EN.
module tb_dbg_access_arbiter;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NR-1:0]     req_valid_i;
  logic [NR-1:0]     req_write_i;
  logic [NR*AW-1:0]  req_addr_i;
  logic [NR*DW-1:0]  req_wdata_i;
  logic [NR-1:0]     req_ready_o;
  logic [NR-1:0]     req_error_o;
  logic [DW-1:0]     req_rdata_o;
  logic [NR-1:0]     grant_o;
  logic              busy_o;
  logic [AW-1:0]     addr_o;
  logic [DW-1:0]     wdata_o;
  logic              write_o;
  logic              enable_o;
  logic [DW-1:0]     rdata_i;
  logic              ready_i;
  logic              error_i;

  int checks = 0;
  int errors = 0;

  dbg_access_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o), .req_error_o(req_error_o),
    .req_rdata_o(req_rdata_o), .grant_o(grant_o), .busy_o(busy_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .write_o(write_o),
    .enable_o(enable_o), .rdata_i(rdata_i), .ready_i(ready_i),
    .error_i(error_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},   32'(grant_o), 32'd0);
    check({tag, "_enable"},  32'(enable_o), 32'd0);
    check({tag, "_busy"},    32'(busy_o), 32'd0);
    check({tag, "_ready"},   32'(req_ready_o), 32'd0);
    check({tag, "_error"},   32'(req_error_o), 32'd0);
    check({tag, "_rdata"},   req_rdata_o, 32'd0);
    check({tag, "_addr"},    addr_o, 32'd0);
    check({tag, "_wdata"},   wdata_o, 32'd0);
    check({tag, "_write"},   32'(write_o), 32'd0);
  endtask

  initial begin
    logic [NR-1:0] exp_g [4];
    int            en_ok;

    rst_i       = 1'b1;
    req_valid_i = '0;
    req_write_i = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    rdata_i     = '0;
    ready_i     = 1'b0;
    error_i     = 1'b0;

    // ---- reset values
    tick();
    tick();
    check_all_zero("reset");
    rst_i = 1'b0;
    tick();

    // ---- all requesters valid, immediate ready: grants 001,010,100,001
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    req_valid_i = 3'b111;
    ready_i     = 1'b1;
    rdata_i     = 32'hA5A5_0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr_grant%0d", k), 32'(grant_o), 32'(exp_g[k]));
      check($sformatf("rr_enable%0d", k), 32'(enable_o), 32'd1);
      tick();
      check($sformatf("rr_ready%0d", k), 32'(req_ready_o), 32'(exp_g[k]));
      check($sformatf("rr_rdata%0d", k), req_rdata_o, 32'hA5A5_0000);
      tick();
      check($sformatf("rr_idle%0d", k), 32'(busy_o), 32'd0);
    end
    req_valid_i = '0;
    ready_i     = 1'b0;
    tick();

    // ---- single read from requester 1, ready 4 cycles after enable
    req_addr_i[1*AW +: AW] = 32'h0000_0040;
    req_valid_i = 3'b010;
    tick();
    check("rd_grant", 32'(grant_o), 32'b010);
    check("rd_enable", 32'(enable_o), 32'd1);
    check("rd_busy", 32'(busy_o), 32'd1);
    check("rd_addr", addr_o, 32'h0000_0040);
    check("rd_write", 32'(write_o), 32'd0);
    req_addr_i[1*AW +: AW] = 32'h0000_0FFF;  // ignored after grant
    for (int k = 0; k < 3; k++) tick();
    check("rd_wait_enable", 32'(enable_o), 32'd1);
    check("rd_wait_ready", 32'(req_ready_o), 32'd0);
    check("rd_addr_stable", addr_o, 32'h0000_0040);
    ready_i = 1'b1;
    rdata_i = 32'hDEAD_BEEF;
    tick();
    ready_i = 1'b0;
    rdata_i = '0;
    check("rd_resp_ready", 32'(req_ready_o), 32'b010);
    check("rd_resp_error", 32'(req_error_o), 32'b000);
    check("rd_resp_rdata", req_rdata_o, 32'hDEAD_BEEF);
    check("rd_resp_enable", 32'(enable_o), 32'd0);
    req_valid_i = '0;
    tick();
    check("rd_done_ready", 32'(req_ready_o), 32'd0);
    check("rd_done_grant", 32'(grant_o), 32'd0);

    // ---- write from requester 2 with downstream error
    req_addr_i[2*AW +: AW]  = 32'h0000_0080;
    req_wdata_i[2*DW +: DW] = 32'h1234_5678;
    req_write_i = 3'b100;
    req_valid_i = 3'b100;
    tick();
    check("wr_grant", 32'(grant_o), 32'b100);
    check("wr_wdata", wdata_o, 32'h1234_5678);
    check("wr_write", 32'(write_o), 32'd1);
    check("wr_addr", addr_o, 32'h0000_0080);
    ready_i = 1'b1;
    error_i = 1'b1;
    rdata_i = 32'hFFFF_FFFF;
    tick();
    ready_i = 1'b0;
    error_i = 1'b0;
    rdata_i = '0;
    check("wr_resp_ready", 32'(req_ready_o), 32'b100);
    check("wr_resp_error", 32'(req_error_o), 32'b100);
    check("wr_resp_rdata", req_rdata_o, 32'd0);
    req_valid_i = '0;
    req_write_i = '0;
    tick();

    // ---- unacknowledged read from requester 0 (pointer now 2 -> wraps to 0)
    req_valid_i = 3'b001;
    tick();
    check("to_grant", 32'(grant_o), 32'b001);
`ifdef DBG_ARB_TIMEOUT_EN
    en_ok = 1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (enable_o !== 1'b1) en_ok = 0;
    end
    check("to_enable_held16", 32'(en_ok), 32'd1);
    tick();
    check("to_enable_drop", 32'(enable_o), 32'd0);
    check("to_ready", 32'(req_ready_o), 32'b001);
    check("to_error", 32'(req_error_o), 32'b001);
    check("to_rdata", req_rdata_o, 32'd0);
    req_valid_i = '0;
    tick();
    for (int k = 0; k < 3; k++) tick();
    ready_i = 1'b1;
    rdata_i = 32'h5555_AAAA;
    tick();
    check("to_late_ready", 32'(req_ready_o), 32'd0);
    check("to_late_busy", 32'(busy_o), 32'd0);
    ready_i = 1'b0;
    rdata_i = '0;
    tick();
`else
    en_ok = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (enable_o !== 1'b1 || req_ready_o !== 3'b000) en_ok = 0;
    end
    check("nto_enable_held", 32'(en_ok), 32'd1);
    ready_i = 1'b1;
    rdata_i = 32'h0000_1111;
    tick();
    ready_i = 1'b0;
    rdata_i = '0;
    check("nto_ready", 32'(req_ready_o), 32'b001);
    check("nto_error", 32'(req_error_o), 32'b000);
    check("nto_rdata", req_rdata_o, 32'h0000_1111);
    req_valid_i = '0;
    tick();
`endif

    // ---- reset mid-access (pointer 0 -> requester 1 granted)
    req_valid_i = 3'b010;
    req_addr_i[1*AW +: AW] = 32'h0000_0044;
    tick();
    check("rstm_grant", 32'(grant_o), 32'b010);
    rst_i   = 1'b1;
    ready_i = 1'b1;
    #1;
    check_all_zero("rstm_async");
    req_valid_i = '0;
    tick();
    rst_i = 1'b0;
    tick();  // stale ready_i in IDLE
    check("rstm_stale_ready", 32'(req_ready_o), 32'd0);
    check("rstm_stale_busy", 32'(busy_o), 32'd0);
    ready_i = 1'b0;

    // ---- requester 0 first after reset, then drops valid mid-access
    req_valid_i = 3'b011;
    tick();
    check("drop_grant0", 32'(grant_o), 32'b001);
    req_valid_i = 3'b010;
    tick();
    check("drop_enable", 32'(enable_o), 32'd1);
    check("drop_grant_held", 32'(grant_o), 32'b001);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("drop_ready0", 32'(req_ready_o), 32'b001);
    tick();
    tick();
    check("drop_next_grant", 32'(grant_o), 32'b010);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("drop_ready1", 32'(req_ready_o), 32'b010);
    req_valid_i = '0;
    tick();
    check("final_idle", 32'(busy_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
